// File: rtl/demux_1x16_loader.sv
// Serial-to-parallel word loader: distributes a valid/ready stream of words
// into NUM parallel slot registers, slot 0 first, then presents the frame
// with out_valid until the consumer acknowledges it.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no frame in progress; last frame held on out_bus
// FILL    | accepting words; idx selects the slot written next
// FULL    | all slots written; frame frozen until out_ack
module demux_1x16_loader #(
    parameter int WIDTH = 16,
    parameter int NUM   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic [3:0]           idx,
    output logic [NUM*WIDTH-1:0] out_bus,
    output logic                 out_valid,
    input  logic                 out_ack,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM - 1);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic             wr_en;
    logic [WIDTH-1:0] slot_q [NUM];

    // State and slot index register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Slot registers: only the slot addressed by idx changes, and only on an accepted word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM; k++) begin
                slot_q[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < NUM; k++) begin
                if (idx_q == 4'(k)) begin
                    slot_q[k] <= in_data;
                end
            end
        end
    end

    // Next-state, index advance and write enable; start outranks a word in the same cycle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    idx_d   = 4'd0;
                end
            end
            ST_FILL: begin
                if (start) begin
                    idx_d = 4'd0;
                end else if (in_valid) begin
                    wr_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        state_d = ST_FULL;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_FULL: begin
                if (out_ack) begin
                    state_d = start ? ST_FILL : ST_IDLE;
                    idx_d   = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state_q == ST_FILL);
        out_valid = (state_q == ST_FULL);
        busy      = (state_q == ST_FILL) || (state_q == ST_FULL);
        idx       = idx_q;
    end

    // Flatten slot registers onto the parallel bus, slot k at bits [k*WIDTH +: WIDTH]
    always_comb begin
        out_bus = '0;
        for (int k = 0; k < NUM; k++) begin
            out_bus[k*WIDTH +: WIDTH] = slot_q[k];
        end
    end

endmodule

// File: tb/tb_demux_1x16_loader.sv
// Bench for demux_1x16_loader: directed frames from the test plan followed by
// random traffic, all compared against a frame-level reference model.
module tb_demux_1x16_loader;

    localparam int WIDTH = 16;
    localparam int NUM   = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 in_ready;
    logic [3:0]           idx;
    logic [NUM*WIDTH-1:0] out_bus;
    logic                 out_valid;
    logic                 out_ack;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = idle, 1 = filling, 2 = frame full
    int               m_mode = 0;
    int               m_idx  = 0;
    logic [WIDTH-1:0] m_slot [NUM];

    demux_1x16_loader #(.WIDTH(WIDTH), .NUM(NUM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .idx       (idx),
        .out_bus   (out_bus),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NUM*WIDTH-1:0] obs, input logic [NUM*WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference model, driven by the inputs seen at that edge
    task automatic model_edge(input logic r, input logic s, input logic v, input logic [WIDTH-1:0] d, input logic a);
        if (!r) begin
            m_mode = 0;
            m_idx  = 0;
            for (int k = 0; k < NUM; k++) m_slot[k] = '0;
        end else if (m_mode == 0) begin
            if (s) begin
                m_mode = 1;
                m_idx  = 0;
            end
        end else if (m_mode == 1) begin
            if (s) begin
                m_idx = 0;
            end else if (v) begin
                m_slot[m_idx] = d;
                m_idx = (m_idx + 1) % NUM;
                if (m_idx == 0) m_mode = 2;
            end
        end else begin
            if (a) begin
                m_mode = s ? 1 : 0;
                m_idx  = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NUM*WIDTH-1:0] exp_bus;
        for (int k = 0; k < NUM; k++) exp_bus[k*WIDTH +: WIDTH] = m_slot[k];
        chk({tag, "_in_ready"},  {255'b0, in_ready},  {255'b0, (m_mode == 1)});
        chk({tag, "_out_valid"}, {255'b0, out_valid}, {255'b0, (m_mode == 2)});
        chk({tag, "_busy"},      {255'b0, busy},      {255'b0, (m_mode != 0)});
        chk({tag, "_idx"},       {252'b0, idx},       (NUM*WIDTH)'(m_idx));
        chk({tag, "_out_bus"},   out_bus,             exp_bus);
    endtask

    // Apply one cycle of inputs, clock it, then compare everything after the edge
    task automatic cyc(input string tag, input logic r, input logic s, input logic v, input logic [WIDTH-1:0] d, input logic a);
        rst_n    = r;
        start    = s;
        in_valid = v;
        in_data  = d;
        out_ack  = a;
        @(posedge clk);
        model_edge(r, s, v, d, a);
        #1;
        check_all(tag);
    endtask

    task automatic load_frame(input string tag, input logic [WIDTH-1:0] base, input bit gaps);
        int n;
        n = 0;
        while (n < NUM) begin
            if (gaps && (n % 2 == 1) && in_valid) begin
                cyc(tag, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
            end else begin
                cyc(tag, 1'b1, 1'b0, 1'b1, base + WIDTH'(n), 1'b0);
                n++;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [WIDTH-1:0] base);
        for (int k = 0; k < NUM; k++)
            chk(tag, {240'b0, out_bus[k*WIDTH +: WIDTH]}, {240'b0, base + WIDTH'(k)});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ack = 1'b0;

        cyc("rst", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        cyc("rst", 1'b0, 1'b1, 1'b1, 16'h5555, 1'b1);

        // Frame of consecutive words
        cyc("t1_start", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        load_frame("t1_fill", 16'h1000, 1'b0);
        chk("t1_out_valid_after_last", {255'b0, out_valid}, {255'b0, 1'b1});
        chk("t1_slot0", {240'b0, out_bus[15:0]}, {240'b0, 16'h1000});
        chk("t1_slot15", {240'b0, out_bus[255:240]}, {240'b0, 16'h100F});
        check_frame("t1_slots", 16'h1000);

        // Same frame with bubbles on in_valid
        cyc("t2_ack", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        cyc("t2_start", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        load_frame("t2_fill", 16'h1000, 1'b1);
        chk("t2_out_valid", {255'b0, out_valid}, {255'b0, 1'b1});
        check_frame("t2_slots", 16'h1000);

        // FULL ignores data and start
        for (int i = 0; i < 3; i++) cyc("t3_hold", 1'b1, 1'b1, 1'b1, 16'hDEAD, 1'b0);
        check_frame("t3_frozen", 16'h1000);
        cyc("t3_ack", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("t3_idle_valid", {255'b0, out_valid}, {255'b0, 1'b0});
        chk("t3_idle_busy", {255'b0, busy}, {255'b0, 1'b0});
        cyc("t3_idle_ignore", 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1);
        check_frame("t3_idle_hold", 16'h1000);

        // Mid-frame restart drops the word presented with start
        cyc("t4_start", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) cyc("t4_a", 1'b1, 1'b0, 1'b1, 16'hA000 + 16'(i), 1'b0);
        cyc("t4_restart", 1'b1, 1'b1, 1'b1, 16'hBBBB, 1'b0);
        chk("t4_idx_zero", {252'b0, idx}, 256'd0);
        load_frame("t4_fill", 16'hC000, 1'b0);
        check_frame("t4_slots", 16'hC000);

        // ack and start together go straight to FILL
        cyc("t5_ack_start", 1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        chk("t5_in_ready", {255'b0, in_ready}, {255'b0, 1'b1});
        load_frame("t5_fill", 16'h0001, 1'b0);
        chk("t5_slot15", {240'b0, out_bus[255:240]}, {240'b0, 16'h0010});
        check_frame("t5_slots", 16'h0001);

        // Reset mid-frame
        cyc("t6_ack", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        cyc("t6_start", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) cyc("t6_a", 1'b1, 1'b0, 1'b1, 16'h7700 + 16'(i), 1'b0);
        cyc("t6_reset", 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
        chk("t6_bus_zero", out_bus, '0);
        chk("t6_in_ready", {255'b0, in_ready}, 256'd0);
        cyc("t6_start2", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        load_frame("t6_fill", 16'h2000, 1'b0);
        check_frame("t6_slots", 16'h2000);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic r, s, v, a;
            logic [WIDTH-1:0] d;
            r = ($urandom_range(0, 99) != 0);
            s = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 3) == 0);
            d = WIDTH'($urandom);
            cyc("rand", r, s, v, d, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
